// File: rtl/self_trigger_gen.sv
// rtl/self_trigger_gen.sv - delays the self-trigger pulse and expands it into a tagged trigger burst
// Busy is decoded straight from the state register so an async reset clears it without a clock edge.
module self_trigger_gen #(
  parameter int DLY_DEPTH = 64,
  parameter int TAG_W     = 5,
  parameter int CNT_W     = 16,
  localparam int DLY_W    = $clog2(DLY_DEPTH)
) (
  input  logic             Clk40,
  input  logic             Reset_b,
  input  logic             SelfTrigger,
  input  logic             EnSelfTrigGen,
  input  logic [DLY_W-1:0] TrigDelay,
  input  logic [3:0]       TrigMult,
  input  logic [7:0]       DeadTime,
  input  logic             ClearCnt,
  output logic             TrigOut,
  output logic [TAG_W-1:0] TrigTag,
  output logic             Busy,
  output logic [CNT_W-1:0] DroppedCnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_DEAD
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [DLY_DEPTH-1:0] sr;
  logic                 dly_trig;
  logic                 request;
  logic [3:0]           burst_cnt;
  logic [3:0]           burst_cnt_next;
  logic [7:0]           dead_cnt;
  logic [7:0]           dead_cnt_next;
  logic [TAG_W-1:0]     next_tag;
  logic [TAG_W-1:0]     next_tag_next;
  logic [TAG_W-1:0]     tag_next;
  logic                 trig_next;
  logic [CNT_W-1:0]     drop_next;

  // Disabling the generator flushes the line so stale pulses cannot fire on re-enable.
  always_ff @(posedge Clk40 or negedge Reset_b) begin
    if (!Reset_b) begin
      sr <= '0;
    end else if (!EnSelfTrigGen) begin
      sr <= '0;
    end else begin
      sr <= {sr[DLY_DEPTH-2:0], SelfTrigger};
    end
  end

  assign dly_trig = sr[TrigDelay];
  assign request  = dly_trig & EnSelfTrigGen;
  assign Busy     = (state != S_IDLE);

  always_ff @(posedge Clk40 or negedge Reset_b) begin
    if (!Reset_b) begin
      state      <= S_IDLE;
      burst_cnt  <= '0;
      dead_cnt   <= '0;
      next_tag   <= '0;
      TrigOut    <= 1'b0;
      TrigTag    <= '0;
      DroppedCnt <= '0;
    end else begin
      state      <= state_next;
      burst_cnt  <= burst_cnt_next;
      dead_cnt   <= dead_cnt_next;
      next_tag   <= next_tag_next;
      TrigOut    <= trig_next;
      TrigTag    <= tag_next;
      DroppedCnt <= drop_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (request) state_next = S_BURST;
      S_BURST: if (burst_cnt == 4'd0) state_next = (DeadTime != 8'd0) ? S_DEAD : S_IDLE;
      S_DEAD:  if (dead_cnt == 8'd0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    trig_next      = 1'b0;
    burst_cnt_next = burst_cnt;
    dead_cnt_next  = dead_cnt;
    next_tag_next  = next_tag;
    tag_next       = TrigTag;
    drop_next      = DroppedCnt;
    unique case (state)
      S_IDLE: begin
        if (request) begin
          trig_next      = 1'b1;
          burst_cnt_next = TrigMult;
          tag_next       = next_tag;
          next_tag_next  = next_tag + TAG_W'(1);
        end
      end
      S_BURST: begin
        if (burst_cnt != 4'd0) begin
          trig_next      = 1'b1;
          burst_cnt_next = burst_cnt - 4'd1;
        end else if (DeadTime != 8'd0) begin
          dead_cnt_next = DeadTime - 8'd1;
        end
      end
      S_DEAD: begin
        if (dead_cnt != 8'd0) dead_cnt_next = dead_cnt - 8'd1;
      end
      default: trig_next = 1'b0;
    endcase
    if (ClearCnt) begin
      drop_next = '0;
    end else if (request && (state != S_IDLE) && (DroppedCnt != '1)) begin
      drop_next = DroppedCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_self_trigger_gen.sv
// tb/tb_self_trigger_gen.sv - directed bench for self_trigger_gen with a cycle-level burst-window model
// The model tracks each accepted burst as a [start, start+len+dead) window over absolute cycle numbers.
`timescale 1ns/1ps
module tb_self_trigger_gen;

  localparam int DLY_DEPTH = 64;
  localparam int TAG_W     = 5;
  localparam int CNT_W     = 12;
  localparam int DLY_W     = $clog2(DLY_DEPTH);
  localparam int HIST      = 16384;

  logic             Clk40 = 1'b0;
  logic             Reset_b = 1'b0;
  logic             SelfTrigger = 1'b0;
  logic             EnSelfTrigGen = 1'b0;
  logic [DLY_W-1:0] TrigDelay = '0;
  logic [3:0]       TrigMult = '0;
  logic [7:0]       DeadTime = '0;
  logic             ClearCnt = 1'b0;
  logic             TrigOut;
  logic [TAG_W-1:0] TrigTag;
  logic             Busy;
  logic [CNT_W-1:0] DroppedCnt;

  self_trigger_gen #(.DLY_DEPTH(DLY_DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .Clk40(Clk40), .Reset_b(Reset_b), .SelfTrigger(SelfTrigger), .EnSelfTrigGen(EnSelfTrigGen),
    .TrigDelay(TrigDelay), .TrigMult(TrigMult), .DeadTime(DeadTime), .ClearCnt(ClearCnt),
    .TrigOut(TrigOut), .TrigTag(TrigTag), .Busy(Busy), .DroppedCnt(DroppedCnt)
  );

  always #12 Clk40 = ~Clk40;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge Clk40) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model state: current burst window, tags, drop count, delay-line history.
  bit st_hist [HIST];
  int first_valid = 0;
  int last_dis = -1;
  int b_start = -1000;
  int b_len = 0;
  int b_dead = 0;
  int m_tag = 0;
  int m_next = 0;
  int m_drop = 0;

  always @(negedge Clk40) begin
    int  j;
    bit  e_trig, e_busy, dly, req;
    if (!Reset_b) begin
      b_start = -1000; b_len = 0; b_dead = 0;
      m_tag = 0; m_next = 0; m_drop = 0;
      first_valid = cyc + 1; last_dis = -1;
      check("rst_trig", TrigOut, 0);
      check("rst_busy", Busy, 0);
      check("rst_tag", TrigTag, 0);
      check("rst_drop", DroppedCnt, 0);
    end else begin
      e_trig = (cyc >= b_start) && (cyc < b_start + b_len);
      e_busy = (cyc >= b_start) && (cyc < b_start + b_len + b_dead);
      check("trig", TrigOut, e_trig);
      check("busy", Busy, e_busy);
      check("tag", TrigTag, m_tag);
      check("drop", DroppedCnt, m_drop);
      if (cyc < HIST) st_hist[cyc] = SelfTrigger;
      j = cyc - 1 - int'(TrigDelay);
      dly = (j >= 0) && (j >= first_valid) && (j > last_dis) && st_hist[j];
      if (!EnSelfTrigGen) last_dis = cyc;
      req = dly && EnSelfTrigGen;
      if (req && !e_busy) begin
        b_start = cyc + 1;
        b_len   = int'(TrigMult) + 1;
        b_dead  = int'(DeadTime);
        m_tag   = m_next;
        m_next  = (m_next + 1) % (1 << TAG_W);
      end
      if (ClearCnt) m_drop = 0;
      else if (req && e_busy && m_drop < (1 << CNT_W) - 1) m_drop = m_drop + 1;
    end
  end

  int trig_n, busy_n, first_trig;
  bit prev_trig;
  int tags[$];

  task automatic tick();
    @(posedge Clk40);
    #1;
    if (TrigOut) begin
      trig_n++;
      if (!prev_trig) begin
        tags.push_back(int'(TrigTag));
        if (first_trig < 0) first_trig = cyc;
      end
    end
    if (Busy) busy_n++;
    prev_trig = TrigOut;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clr_stats();
    trig_n = 0; busy_n = 0; first_trig = -1; prev_trig = 1'b0;
    tags.delete();
  endtask

  task automatic do_reset();
    Reset_b = 1'b0; SelfTrigger = 1'b0; ClearCnt = 1'b0;
    idle(2);
    Reset_b = 1'b1;
  endtask

  task automatic pulse();
    SelfTrigger = 1'b1;
    tick();
    SelfTrigger = 1'b0;
  endtask

  task automatic wait_trig(input string name);
    int w = 0;
    while (!TrigOut && w < 100) begin
      tick();
      w++;
    end
    check(name, TrigOut, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    clr_stats();
    // Single pulse, latency TrigDelay+2
    do_reset();
    EnSelfTrigGen = 1'b1; TrigDelay = 10; TrigMult = 0; DeadTime = 0;
    idle(5); clr_stats();
    s = cyc; pulse(); idle(30);
    check("s1_latency", first_trig - s, 12);
    check("s1_pulses", trig_n, 1);
    check("s1_busy", busy_n, 1);
    check("s1_tag", TrigTag, 0);

    // Burst of 4 + 5 dead cycles; second request lands 6 cycles after first pulse
    do_reset();
    TrigMult = 3; DeadTime = 5;
    idle(5); clr_stats();
    s = cyc; pulse(); idle(6); pulse(); idle(40);
    check("s2_latency", first_trig - s, 12);
    check("s2_pulses", trig_n, 4);
    check("s2_busy", busy_n, 9);
    check("s2_drop", DroppedCnt, 1);
    check("s2_tag", TrigTag, 0);

    // Back-to-back bursts with no dead time
    do_reset();
    TrigMult = 1; DeadTime = 0;
    idle(5); clr_stats();
    for (int k = 0; k < 4; k++) begin
      pulse(); idle(2);
    end
    idle(30);
    check("s3_pulses", trig_n, 8);
    check("s3_busy", busy_n, 8);
    check("s3_bursts", tags.size(), 4);
    if (tags.size() == 4) for (int k = 0; k < 4; k++) check("s3_tag_seq", tags[k], k);
    check("s3_drop", DroppedCnt, 0);

    // Tag wrap over 33 bursts
    do_reset();
    TrigMult = 0; DeadTime = 0; TrigDelay = 0;
    idle(3); clr_stats();
    repeat (33) begin
      pulse(); idle(3);
    end
    idle(5);
    check("s4_bursts", tags.size(), 33);
    if (tags.size() == 33) begin
      check("s4_tag31", tags[31], 31);
      check("s4_tag_wrap", tags[32], 0);
    end
    check("s4_final_tag", TrigTag, 0);

    // Drop counter saturation, then clear coincident with a drop
    do_reset();
    TrigMult = 15; DeadTime = 255; TrigDelay = 0;
    idle(2);
    SelfTrigger = 1'b1;
    idle(4300);
    check("s4_sat", DroppedCnt, (1 << CNT_W) - 1);
    begin
      int w = 0;
      while (!Busy && w < 300) begin
        tick();
        w++;
      end
    end
    check("s4_busy_before_clr", Busy, 1);
    ClearCnt = 1'b1; SelfTrigger = 1'b0;
    tick();
    ClearCnt = 1'b0;
    check("s4_clear_wins", DroppedCnt, 0);
    idle(3);
    check("s4_clear_hold", DroppedCnt, 0);
    idle(300);

    // Enable dropped mid-burst: burst and dead time finish, later pulses ignored
    do_reset();
    EnSelfTrigGen = 1'b1; TrigMult = 7; DeadTime = 3; TrigDelay = 5;
    idle(3); clr_stats();
    pulse();
    wait_trig("s5_first_trig");
    idle(2);
    EnSelfTrigGen = 1'b0;
    repeat (3) begin
      pulse(); idle(2);
    end
    idle(30);
    check("s5_pulses", trig_n, 8);
    check("s5_busy", busy_n, 11);
    check("s5_bursts", tags.size(), 1);
    check("s5_drop", DroppedCnt, 0);

    // Async reset mid-burst clears outputs without a clock edge
    EnSelfTrigGen = 1'b1;
    idle(70);
    pulse();
    wait_trig("s6_first_trig");
    idle(2);
    check("s6_pre_tag", TrigTag, 1);
    check("s6_pre_busy", Busy, 1);
    #2;
    Reset_b = 1'b0;
    #1;
    check("s6_async_trig", TrigOut, 0);
    check("s6_async_busy", Busy, 0);
    check("s6_async_tag", TrigTag, 0);
    idle(2);
    Reset_b = 1'b1;
    clr_stats();
    idle(20);
    check("s6_post_pulses", trig_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/self_trigger_gen.md
Name: self_trigger_gen

Overview:
- Sits directly downstream of the end-of-column self-trigger OR stage.
- Consumes its registered SelfTrigger pulse, delays it by a programmable latency, and expands it into a burst of consecutive-BX trigger pulses.
- Applies a programmable dead time after each burst, tags each burst, and counts requests dropped while busy.
- TrigOut feeds the chip trigger path in place of a command-decoded trigger.

Parameters:
- DLY_DEPTH, 64, depth of the latency shift register (power of 2).
- TAG_W, 5, width of the burst tag counter.
- CNT_W, 16, width of the dropped-request counter.

Ports:
- Clk40  input  1  40 MHz bunch-crossing clock, single clock domain.
- Reset_b  input  1  asynchronous active-low reset.
- SelfTrigger  input  1  self-trigger pulse from the upstream stage, already synchronous to Clk40.
- EnSelfTrigGen  input  1  enables trigger generation.
- TrigDelay  input  log2(DLY_DEPTH)  latency tap select.
- TrigMult  input  4  burst length minus one (1..16 pulses).
- DeadTime  input  8  idle cycles enforced after each burst.
- ClearCnt  input  1  synchronous clear of DroppedCnt.
- TrigOut  output  1  registered trigger pulse, one per BX of the burst.
- TrigTag  output  TAG_W  tag of the current or most recent burst.
- Busy  output  1  high while state is BURST or DEAD.
- DroppedCnt  output  CNT_W  requests lost while busy, saturating.

Behaviour:
- Reset (async, Reset_b=0):
  - All outputs are 0: TrigOut, TrigTag, Busy, DroppedCnt.
  - Shift register cleared, state=IDLE, next-tag counter=0, burst and dead counters=0.
- Delay line:
  - Each cycle, sr <= {sr[DLY_DEPTH-2:0], SelfTrigger}.
  - DlyTrig = sr[TrigDelay].
  - While EnSelfTrigGen=0, sr is held at all-zeros (flushed).
- Latency: a SelfTrigger high in cycle N gives the first TrigOut high in cycle N+TrigDelay+2.
- Request definition: a request is DlyTrig=1 AND EnSelfTrigGen=1, sampled each cycle. Each high cycle of DlyTrig is a separate request.
- FSM states IDLE, BURST, DEAD (all registered):
  - IDLE + request:
    - go to BURST; TrigOut<=1; burst counter<=TrigMult.
    - TrigTag<=next-tag; next-tag<=next-tag+1, wrapping 2^TAG_W-1 -> 0.
  - BURST:
    - if burst counter>0: TrigOut<=1, counter decrements.
    - if burst counter=0: TrigOut<=0; go to DEAD with dead counter<=DeadTime-1 if DeadTime>0, else go to IDLE.
  - DEAD: counts down; at 0, go to IDLE. Exactly DeadTime cycles elapse with TrigOut=0 before a new burst can start.
  - With DeadTime=0 and back-to-back requests, a new burst starts the cycle after the last pulse. This leaves a one-cycle TrigOut gap, which is required.
- Burst length: TrigOut is high for exactly TrigMult+1 consecutive cycles.
- Busy: high exactly when the registered state is BURST or DEAD.
- Dropped requests:
  - A request arriving in BURST or DEAD does not start a burst and increments DroppedCnt.
  - DroppedCnt saturates at 2^CNT_W-1.
  - ClearCnt=1 sets DroppedCnt to 0; when clear and drop occur in the same cycle, clear wins (result 0).
- Enable deasserted mid-burst:
  - The current burst and dead time complete normally.
  - No new bursts start and no drops are counted while disabled.
- Configuration sampling:
  - TrigMult and DeadTime are sampled only at burst start (TrigMult) and at the BURST->DEAD transition (DeadTime). Changes during a burst do not affect it.
  - A TrigDelay change takes effect immediately. Missed or duplicate requests around the change are permitted.
- TrigTag holds its value between bursts.

Test Plan:
- Single pulse: reset; En=1, TrigDelay=10, TrigMult=0, DeadTime=0; SelfTrigger high at cycle 100 -> TrigOut high in cycle 112 only; TrigTag=0; Busy high 1 cycle.
- Burst plus dead time: TrigMult=3, DeadTime=5; one request -> TrigOut high 4 cycles, Busy high 9 cycles; second request 6 cycles after first TrigOut -> DroppedCnt=1.
- Back-to-back with DeadTime=0, TrigMult=1: requests 3 cycles apart ×4 -> 4 bursts of 2 pulses each; TrigTag 0,1,2,3; DroppedCnt=0.
- Tag wrap and saturation: 33 isolated bursts -> TrigTag sequence wraps 31 -> 0, final tag=0. Force DroppedCnt to 0xFFFF via drops -> it holds 0xFFFF; ClearCnt coincident with a drop -> 0.
- Enable and reset: deassert En mid-burst (TrigMult=7) -> all 8 pulses are emitted and later requests are ignored with no drop count. Assert Reset_b=0 asynchronously mid-burst -> TrigOut, Busy, and TrigTag go 0 immediately, without waiting for a clock edge.
